// File: rtl/uwoc_rx_link_ctrl.sv
// Link bring-up controller for the UWOC receive chain: arms the RX front end, kicks sync,
// watches lock/frame status, retries with rate fallback and reports link state.
module uwoc_rx_link_ctrl #(
    parameter int MAX_RETRY     = 3,
    parameter int GAP_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 32768,
    parameter int FRAME_TIMEOUT = 131072
) (
    input  logic       clk_130M,
    input  logic       rst_n,
    input  logic       ctrl_go,
    input  logic       ctrl_abort,
    input  logic [2:0] cfg_rate_init,
    input  logic       cfg_auto_fallback,
    input  logic       sync_locked,
    input  logic       frame_sync_ok,
    input  logic       frame_sync_fail,
    output logic       rx_en,
    output logic       rx_start,
    output logic [2:0] rate_sel,
    output logic       busy,
    output logic       link_up,
    output logic       link_fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] st_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_START      = 3'd2,
        S_WAIT_LOCK  = 3'd3,
        S_WAIT_FRAME = 3'd4,
        S_UP         = 3'd5,
        S_BACKOFF    = 3'd6,
        S_FAIL       = 3'd7
    } state_t;

    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIM  = 4'(MAX_RETRY);

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic [3:0]  retry_nxt;
    logic [2:0]  rate_nxt;
    logic        attempt_fail;

    always_comb begin
        state_nxt    = state;
        retry_nxt    = retry_cnt;
        rate_nxt     = rate_sel;
        attempt_fail = 1'b0;
        if (ctrl_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FAIL: begin
                    if (ctrl_go) begin
                        state_nxt = S_ARM;
                        rate_nxt  = (cfg_rate_init <= 3'd5) ? cfg_rate_init : 3'd0;
                        retry_nxt = 4'd0;
                    end
                end
                S_ARM:   if (timer == GAP_LAST) state_nxt = S_START;
                S_START: state_nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (sync_locked)              state_nxt = S_WAIT_FRAME;
                    else if (timer == LOCK_LAST)  attempt_fail = 1'b1;
                end
                // Explicit failure indications outrank frame_sync_ok; ok outranks timeout.
                S_WAIT_FRAME: begin
                    if (frame_sync_fail || !sync_locked) attempt_fail = 1'b1;
                    else if (frame_sync_ok)              state_nxt = S_UP;
                    else if (timer == FRAME_LAST)        attempt_fail = 1'b1;
                end
                S_UP: begin
                    if (!sync_locked) begin
                        state_nxt = S_BACKOFF;
                        retry_nxt = 4'd0;
                    end
                end
                S_BACKOFF: begin
                    if (timer == GAP_LAST) begin
                        if (retry_cnt < RETRY_LIM) begin
                            state_nxt = S_ARM;
                        end else if (cfg_auto_fallback && rate_sel != 3'd0) begin
                            state_nxt = S_ARM;
                            rate_nxt  = rate_sel - 3'd1;
                            retry_nxt = 4'd0;
                        end else begin
                            state_nxt = S_FAIL;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            if (attempt_fail) begin
                state_nxt = S_BACKOFF;
                retry_nxt = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        timer_nxt = 32'd0;
        if (state_nxt == state &&
            (state == S_ARM || state == S_BACKOFF || state == S_WAIT_LOCK || state == S_WAIT_FRAME))
            timer_nxt = timer + 32'd1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk_130M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= 32'd0;
            retry_cnt <= 4'd0;
            rate_sel  <= 3'd0;
            rx_en     <= 1'b0;
            rx_start  <= 1'b0;
            busy      <= 1'b0;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            rate_sel  <= rate_nxt;
            rx_en     <= (state_nxt == S_ARM) || (state_nxt == S_START) ||
                         (state_nxt == S_WAIT_LOCK) || (state_nxt == S_WAIT_FRAME) ||
                         (state_nxt == S_UP);
            rx_start  <= (state_nxt == S_START);
            busy      <= (state_nxt != S_IDLE) && (state_nxt != S_FAIL);
            link_up   <= (state_nxt == S_UP);
            link_fail <= (state_nxt == S_FAIL);
        end
    end

    assign st_dbg = state;

endmodule

// File: tb/tb_uwoc_rx_link_ctrl.sv
// Directed bench for uwoc_rx_link_ctrl: bring-up, link loss, abort, clamping, retry/fallback, reset.
module tb_uwoc_rx_link_ctrl;

    localparam int LOCK_TO = 128;
    localparam int GAP     = 16;

    logic       clk_130M = 1'b0;
    logic       rst_n = 1'b1;
    logic       ctrl_go = 1'b0, ctrl_abort = 1'b0;
    logic [2:0] cfg_rate_init = 3'd0;
    logic       cfg_auto_fallback = 1'b0;
    logic       sync_locked = 1'b0, frame_sync_ok = 1'b0, frame_sync_fail = 1'b0;
    logic       rx_en, rx_start, busy, link_up, link_fail;
    logic [2:0] rate_sel, st_dbg;
    logic [3:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    uwoc_rx_link_ctrl #(
        .MAX_RETRY(3), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(LOCK_TO), .FRAME_TIMEOUT(1024)
    ) dut (
        .clk_130M(clk_130M), .rst_n(rst_n), .ctrl_go(ctrl_go), .ctrl_abort(ctrl_abort),
        .cfg_rate_init(cfg_rate_init), .cfg_auto_fallback(cfg_auto_fallback),
        .sync_locked(sync_locked), .frame_sync_ok(frame_sync_ok), .frame_sync_fail(frame_sync_fail),
        .rx_en(rx_en), .rx_start(rx_start), .rate_sel(rate_sel), .busy(busy),
        .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt), .st_dbg(st_dbg)
    );

    always #5 clk_130M = ~clk_130M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_130M);
            #1;
        end
    endtask

    task automatic pulse_go();
        ctrl_go = 1'b1;
        step(1);
        ctrl_go = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_st", st_dbg, 0);   chk("rst_rx_en", rx_en, 0); chk("rst_rx_start", rx_start, 0);
        chk("rst_rate", rate_sel, 0); chk("rst_busy", busy, 0); chk("rst_link_up", link_up, 0);
        chk("rst_link_fail", link_fail, 0); chk("rst_retry", retry_cnt, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("idle_after_rst", st_dbg, 0);

        // Nominal bring-up at rate 3
        cfg_rate_init = 3'd3;
        pulse_go();
        chk("nom_arm", st_dbg, 1); chk("nom_arm_rx_en", rx_en, 1); chk("nom_arm_busy", busy, 1);
        chk("nom_rate", rate_sel, 3);
        step(15);
        chk("nom_arm_last", st_dbg, 1); chk("nom_no_start_early", rx_start, 0);
        step(1);
        chk("nom_start", st_dbg, 2); chk("nom_rx_start", rx_start, 1);
        step(1);
        chk("nom_wait_lock", st_dbg, 3); chk("nom_start_single", rx_start, 0);
        step(98);
        sync_locked = 1'b1;
        step(1);
        chk("nom_wait_frame", st_dbg, 4);
        step(499);
        frame_sync_ok = 1'b1;
        step(1);
        frame_sync_ok = 1'b0;
        chk("nom_up", st_dbg, 5); chk("nom_link_up", link_up, 1); chk("nom_up_rate", rate_sel, 3);
        chk("nom_up_retry", retry_cnt, 0); chk("nom_up_rx_en", rx_en, 1);

        // Link loss: one-clock drop of sync_locked in UP
        sync_locked = 1'b0;
        step(1);
        sync_locked = 1'b1;
        chk("loss_backoff", st_dbg, 6); chk("loss_link_up", link_up, 0); chk("loss_rx_en", rx_en, 0);
        chk("loss_rate_kept", rate_sel, 3);
        step(15);
        chk("loss_backoff_last", st_dbg, 6); chk("loss_backoff_rx_en", rx_en, 0);
        step(1);
        chk("loss_rearm", st_dbg, 1); chk("loss_rearm_rx_en", rx_en, 1);
        step(16);
        chk("loss_restart", rx_start, 1);
        step(2);
        chk("loss_wait_frame", st_dbg, 4);

        // Abort in WAIT_FRAME
        ctrl_abort = 1'b1;
        step(1);
        ctrl_abort = 1'b0;
        chk("abort_idle", st_dbg, 0); chk("abort_rx_en", rx_en, 0); chk("abort_busy", busy, 0);

        // go and abort together: abort wins
        ctrl_go = 1'b1; ctrl_abort = 1'b1;
        step(1);
        ctrl_go = 1'b0; ctrl_abort = 1'b0;
        chk("go_abort_idle", st_dbg, 0); chk("go_abort_rx_en", rx_en, 0);

        // Out-of-range rate clamps to 0; ok+fail together counts as failure
        cfg_rate_init = 3'd7;
        pulse_go();
        chk("clamp_rate", rate_sel, 0);
        step(18);
        chk("clamp_wait_frame", st_dbg, 4);
        frame_sync_ok = 1'b1; frame_sync_fail = 1'b1;
        step(1);
        frame_sync_ok = 1'b0; frame_sync_fail = 1'b0;
        chk("okfail_backoff", st_dbg, 6); chk("okfail_retry", retry_cnt, 1);
        ctrl_abort = 1'b1;
        step(1);
        ctrl_abort = 1'b0;
        chk("abort_retry_kept", retry_cnt, 1);

        // No fallback: frame_sync_fail each attempt -> FAIL at rate 4
        cfg_rate_init = 3'd4; cfg_auto_fallback = 1'b0;
        pulse_go();
        chk("nofb_retry_clr", retry_cnt, 0);
        for (int k = 1; k <= 3; k++) begin
            step(18);
            chk("nofb_wait_frame", st_dbg, 4);
            if (k == 1) begin
                pulse_go();
                chk("go_ignored", st_dbg, 4);
            end
            frame_sync_fail = 1'b1;
            step(1);
            frame_sync_fail = 1'b0;
            chk("nofb_backoff", st_dbg, 6); chk("nofb_retry", retry_cnt, k);
            step(16);
            chk("nofb_after_backoff", st_dbg, (k < 3) ? 1 : 7);
        end
        chk("nofb_link_fail", link_fail, 1); chk("nofb_rx_en", rx_en, 0);
        chk("nofb_busy", busy, 0); chk("nofb_rate", rate_sel, 4);

        // Fallback: lock never arrives, rate 2 -> 1 -> 0 -> FAIL
        sync_locked = 1'b0; cfg_auto_fallback = 1'b1; cfg_rate_init = 3'd2;
        pulse_go();
        chk("fb_arm", st_dbg, 1); chk("fb_link_fail_clr", link_fail, 0); chk("fb_rate", rate_sel, 2);
        for (int r = 2; r >= 0; r--) begin
            for (int a = 1; a <= 3; a++) begin
                step(17);
                chk("fb_wait_lock", st_dbg, 3);
                step(LOCK_TO - 1);
                chk("fb_lock_last", st_dbg, 3);
                step(1);
                chk("fb_timeout", st_dbg, 6); chk("fb_retry", retry_cnt, a); chk("fb_rate_cur", rate_sel, r);
                step(GAP);
                if (a < 3) begin
                    chk("fb_retry_arm", st_dbg, 1);
                end else if (r > 0) begin
                    chk("fb_step_arm", st_dbg, 1); chk("fb_step_rate", rate_sel, r - 1);
                    chk("fb_step_retry", retry_cnt, 0);
                end else begin
                    chk("fb_fail", st_dbg, 7); chk("fb_link_fail", link_fail, 1); chk("fb_rx_en", rx_en, 0);
                end
            end
        end

        // Reset mid-session in WAIT_LOCK
        cfg_rate_init = 3'd2;
        pulse_go();
        step(17);
        chk("rst_pre_wait_lock", st_dbg, 3);
        rst_n = 1'b0;
        #1;
        chk("mrst_st", st_dbg, 0); chk("mrst_rx_en", rx_en, 0); chk("mrst_rx_start", rx_start, 0);
        chk("mrst_rate", rate_sel, 0); chk("mrst_busy", busy, 0); chk("mrst_retry", retry_cnt, 0);
        chk("mrst_link_up", link_up, 0); chk("mrst_link_fail", link_fail, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("mrst_stay_idle", st_dbg, 0); chk("mrst_stay_rx_en", rx_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uwoc_rx_link_ctrl.md
UWOC_RX_LINK_CTRL -- requirements
Module: uwoc_rx_link_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: failed attempts allowed per rate before fallback or FAIL.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: rx_en-low backoff and rx_en-high arm time, in clocks.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 32768: clocks allowed from rx_start to sync_locked.
REQ-004 SHALL have parameter FRAME_TIMEOUT, default 131072: clocks allowed from lock to frame_sync_ok.
REQ-005 SHALL have ports clk_130M in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports ctrl_go in 1, session start pulse; ctrl_abort in 1, stop request.
REQ-007 SHALL have ports cfg_rate_init in 3, initial rate code; cfg_auto_fallback in 1, enables rate step-down.
REQ-008 SHALL have ports sync_locked in 1, frame_sync_ok in 1 and frame_sync_fail in 1, all status from the RX chain.
REQ-009 SHALL have ports rx_en out 1, rx_start out 1 and rate_sel out 3, all driving the RX chain.
REQ-010 SHALL have ports busy out 1, link_up out 1, link_fail out 1, retry_cnt out 4 and st_dbg out 3 (state code).

Function
REQ-011 SHALL implement states IDLE=0, ARM=1, START=2, WAIT_LOCK=3, WAIT_FRAME=4, UP=5, BACKOFF=6, FAIL=7; st_dbg equals the current state code.
REQ-012 IDLE/FAIL: on ctrl_go, latch rate_sel, clear retry_cnt, clear link_fail, go to ARM.
- Latched rate_sel = cfg_rate_init if the value is 0..5, else 0.
REQ-013 ARM: rx_en=1 for GAP_CYCLES clocks, then go to START.
REQ-014 START: rx_start=1 for exactly one clock, then go to WAIT_LOCK; rx_start SHALL be 0 in every other state.
REQ-015 WAIT_LOCK: sync_locked=1 -> WAIT_FRAME; timer reaching LOCK_TIMEOUT-1 -> attempt failure.
REQ-016 WAIT_FRAME: frame_sync_ok=1 -> UP; frame_sync_fail=1, sync_locked=0, or timer reaching FRAME_TIMEOUT-1 -> attempt failure.
REQ-017 Attempt failure: increment retry_cnt, saturating at 15, then go to BACKOFF.
REQ-018 BACKOFF: rx_en=0 for GAP_CYCLES clocks; at the end, apply the first matching rule:
- retry_cnt < MAX_RETRY -> ARM.
- cfg_auto_fallback=1 and rate_sel > 0 -> rate_sel decrements by 1, retry_cnt clears, go to ARM.
- otherwise -> FAIL.
REQ-019 rate_sel SHALL change only in BACKOFF or on ctrl_go, never while rx_en=1.
REQ-020 UP: link_up=1 and rx_en=1; on sync_locked=0, clear link_up, clear retry_cnt, keep rate_sel, go to BACKOFF.
REQ-021 FAIL: link_fail=1, rx_en=0; remain in FAIL until ctrl_go or reset.
REQ-022 busy=1 in states ARM through BACKOFF, 0 in IDLE and FAIL.
REQ-023 rx_en SHALL be 1 in ARM, START, WAIT_LOCK, WAIT_FRAME and UP, and 0 otherwise.
REQ-024 All outputs SHALL be registered; outputs reflect the new state one clock after the triggering input is sampled.
REQ-025 Timer SHALL be 32-bit, cleared on every state entry, and increment each clock in ARM, BACKOFF, WAIT_LOCK and WAIT_FRAME.
REQ-026 ctrl_abort has highest priority: any state -> IDLE next clock with rx_en=0, link_up=0 and retry_cnt kept.
- ctrl_abort also clears link_fail.
REQ-027 ctrl_go SHALL be ignored in states other than IDLE and FAIL.
REQ-028 If ctrl_go and ctrl_abort are asserted in the same clock, abort SHALL win.
REQ-029 If frame_sync_ok and frame_sync_fail are asserted in the same clock, the cycle SHALL count as a failure.
REQ-030 If frame_sync_ok and a timeout occur in the same clock, frame_sync_ok SHALL win.
REQ-031 If sync_locked and a lock timeout occur in the same clock, sync_locked SHALL win.

Reset
REQ-032 On rst_n=0, state SHALL go to IDLE immediately (asynchronously).
REQ-033 On rst_n=0: rx_en=0, rx_start=0, rate_sel=0, busy=0, link_up=0, link_fail=0, retry_cnt=0, st_dbg=0, timer=0.
REQ-034 Reset asserted mid-session SHALL drop rx_en in the same cycle, with no rx_start glitch.
REQ-035 After reset release, the block SHALL stay in IDLE until ctrl_go.

Verification
REQ-036 SHALL check nominal bring-up: cfg_rate_init=3, ctrl_go; sync_locked 100 clocks after rx_start, frame_sync_ok 500 clocks later.
- Expect rx_start as a single pulse 16 clocks after ctrl_go, then UP with link_up=1, rate_sel=3, retry_cnt=0.
REQ-037 SHALL check fallback: cfg_auto_fallback=1, rate 2, sync_locked held 0.
- Expect 3 lock timeouts at rate 2, then rate_sel=1 with retry_cnt=0.
- Then 3 more timeouts, rate_sel=0, 3 more, then FAIL with link_fail=1 and rx_en=0.
REQ-038 SHALL check no fallback: cfg_auto_fallback=0; frame_sync_fail pulsed in each WAIT_FRAME.
- Expect retry_cnt 1, 2, 3, then FAIL with rate_sel unchanged.
REQ-039 SHALL check link loss: in UP, drop sync_locked for 1 clock.
- Expect link_up=0, BACKOFF with rx_en=0 for 16 clocks, then ARM and a new rx_start pulse.
REQ-040 SHALL check abort and reset: ctrl_go and ctrl_abort in the same clock stays in IDLE; abort in WAIT_FRAME goes to IDLE next clock.
- rst_n pulse in WAIT_LOCK gives all outputs 0 immediately.
REQ-041 SHALL check clamping: cfg_rate_init=7 latches rate_sel=0; simultaneous frame_sync_ok and frame_sync_fail gives retry_cnt +1 and BACKOFF.
